mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Multi-cycle MIPS-I subset core; successor to the single-cycle cpu. One FSM sequences
//  fetch/decode/execute/memory/writeback over a single shared instruction+data memory port
//  with a req/ready handshake, so memory may insert wait states. Contains its own 32x32
//  register file ($0 reads zero). Exposes a retire/writeback trace port for the bench.
// PARAMETERS
//  RESET_PC         32'h0000_0000  PC loaded on reset
//  ADDR_W           32             width of mem_addr (low ADDR_W bits of byte address)
//  HALT_ON_ILLEGAL  1              1: unknown opcode/funct -> HALT; 0: executes as NOP
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  mem_req       out  1       memory transfer request
//  mem_we        out  1       1 = write (sw), 0 = read (fetch, lw)
//  mem_addr      out  ADDR_W  byte address, bits[1:0] always 0
//  mem_wdata     out  32      store data (rt value) when mem_we=1
//  mem_rdata     in   32      read data, valid when mem_req & mem_ready
//  mem_ready     in   1       transfer completes on the edge where mem_req & mem_ready
//  retire        out  1       1-cycle pulse on the last cycle of each instruction
//  retire_pc     out  32      PC of retiring instruction
//  wb_en         out  1       register write this cycle (never for $0)
//  wb_id         out  5       destination register
//  wb_data       out  32      value written
//  halted        out  1       core in HALT state
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, all regs=0; mem_req, mem_we, retire, wb_en, halted=0;
//   mem_addr=RESET_PC, mem_wdata=0. mem_req rises in the first cycle after rst drops.
//   rst has priority in any state, incl. mid-transfer: mem_req drops the next cycle, no write.
//  Instructions: add/sub/and/or/slt (op 0, funct 20/22/24/25/2a), addi(08), lw(23), sw(2b),
//   beq(04), j(02). add/sub/addi wrap mod 2^32, no overflow trap; slt signed; imm sign-extended.
//  States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH; HALT.
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold all outputs stable until mem_ready; on
//   completion IR<=mem_rdata, pc<=pc+4.
//  DECODE: A<=rf[rs], B<=rf[rt]; target<=pc+4+(sext(imm)<<2). Illegal op -> HALT or FETCH
//   (NOP, retire pulses) per HALT_ON_ILLEGAL.
//  EXEC: R/addi -> ALU, go WB. lw/sw: addr=A+sext(imm), go MEM. beq: if A==B pc<=target;
//   retire, go FETCH. j: pc<={pc[31:28],imm26,2'b00}; retire, go FETCH.
//  MEM: mem_req=1, mem_we=(sw), mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wdata=B; wait for
//   mem_ready. sw -> retire, FETCH. lw -> latch mem_rdata, go WB.
//  WB: rf[rd or rt]<=result unless id==0; wb_en=(id!=0) with wb_id/wb_data; retire; FETCH.
//  Register file written only in WB; writes to $0 discarded, $0 always reads 0.
//  Zero-wait CPI: beq/j 3, R/addi/sw 4, lw 5; each wait cycle adds 1.
//  HALT: absorbing until rst; halted=1, mem_req=0, no retire.
//  PC wrap: pc+4 at 32'hFFFF_FFFC wraps to 0, no error.
// TESTING
//  rst high 3 cycles, release, mem_ready=1 -> next cycle mem_req=1, mem_addr=0x0, we=0.
//  addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> wb $3=2, $4=1; retire every 4 cycles.
//  sw $3,8($0) then lw $5,8($0) with mem_ready low 3 cycles per transfer -> write addr 0x8
//   data 2, addr/req stable while waiting; $5=2; lw takes 5+3*2 cycles total.
//  beq $1,$1,+2 at pc 0x10 -> next fetch 0x1C; beq $1,$2 -> next fetch 0x14; j 0x40 -> fetch 0x100.
//  addi $0,$0,7 -> wb_en=0, $0 reads 0; opcode 0x3F -> halted=1, mem_req=0 forever (HALT_ON_ILLEGAL=1).
//  rst asserted during MEM wait of sw -> no write completes, mem_req=0 next cycle, fetch from RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core sharing one memory port for fetch and data.
// One FSM walks FETCH/DECODE/EXEC/MEM/WB, owns a 32x32 register file, and
// exposes a retire/writeback trace.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   mem_req/we/addr/wdata     request side of the shared memory port
//   mem_rdata, mem_ready      response side; a transfer completes on the edge
//                             where mem_req & mem_ready
//   retire, retire_pc         one-cycle pulse on each instruction's last cycle
//   wb_en, wb_id, wb_data     register write trace (never for $0)
//   halted                    core parked in HALT
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic [31:0]       retire_pc,
    output logic              wb_en,
    output logic [4:0]        wb_id,
    output logic [31:0]       wb_data,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] res_q, res_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    // Instruction fields, always taken from the latched IR.
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic [31:0] simm;
    logic [4:0]  dst;

    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic r_ok;
    logic legal;

    logic [31:0] alu_out;
    logic        unused_shamt;

    assign op   = ir_q[31:26];
    assign rs   = ir_q[25:21];
    assign rt   = ir_q[20:16];
    assign rd   = ir_q[15:11];
    assign fn   = ir_q[5:0];
    assign simm = {{16{ir_q[15]}}, ir_q[15:0]};

    assign unused_shamt = ^ir_q[10:6];

    assign is_r    = (op == OP_R);
    assign is_addi = (op == OP_ADDI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);

    assign r_ok = is_r && ((fn == FN_ADD) || (fn == FN_SUB) ||
                           (fn == FN_AND) || (fn == FN_OR)  ||
                           (fn == FN_SLT));

    assign legal = r_ok || is_addi || is_lw || is_sw || is_beq || is_j;

    // R-type writes rd; addi and lw write rt.
    assign dst = is_r ? rd : rt;

    always_comb begin
        alu_out = a_q + simm;
        if (is_r) begin
            case (fn)
                FN_ADD:  alu_out = a_q + b_q;
                FN_SUB:  alu_out = a_q - b_q;
                FN_AND:  alu_out = a_q & b_q;
                FN_OR:   alu_out = a_q | b_q;
                FN_SLT:  alu_out = {31'd0, $signed(a_q) < $signed(b_q)};
                default: alu_out = a_q + b_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ipc_d     = ipc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        tgt_d     = tgt_q;
        res_d     = res_q;
        rf_d      = rf_q;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {pc_q[ADDR_W-1:2], 2'b00};
        mem_wdata = b_q;
        retire    = 1'b0;
        wb_en     = 1'b0;
        wb_id     = dst;
        wb_data   = res_q;
        halted    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                a_d   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
                b_d   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
                // pc_q already holds pc+4 here.
                tgt_d = pc_q + {simm[29:0], 2'b00};
                if (legal) begin
                    state_d = S_EXEC;
                end else if (HALT_ON_ILLEGAL) begin
                    state_d = S_HALT;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXEC: begin
                if (is_beq) begin
                    if (a_q == b_q) begin
                        pc_d = tgt_q;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    res_d   = a_q + simm;
                    state_d = S_MEM;
                end else begin
                    res_d   = alu_out;
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = {res_q[ADDR_W-1:2], 2'b00};
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                retire  = 1'b1;
                wb_en   = (dst != 5'd0);
                if (dst != 5'd0) begin
                    rf_d[dst] = res_q;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset overrides the port combinationally so an in-flight
        // transfer is withdrawn before the edge and no store lands.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = RESET_PC[ADDR_W-1:0];
            mem_wdata = 32'd0;
            retire    = 1'b0;
            wb_en     = 1'b0;
            wb_id     = 5'd0;
            wb_data   = 32'd0;
            halted    = 1'b0;
        end
    end

    assign retire_pc = ipc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ipc_q   <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            tgt_q   <= 32'd0;
            res_q   <= 32'd0;
            rf_q    <= '{default: 32'd0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tgt_q   <= tgt_d;
            res_q   <= res_d;
            rf_q    <= rf_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a wait-state memory model, a
// retire scoreboard (pc, writeback, cycles, next fetch) and a store queue.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        retire;
    logic [31:0] retire_pc;
    logic        wb_en;
    logic [4:0]  wb_id;
    logic [31:0] wb_data;
    logic        halted;

    mips_multicycle_core dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .retire_pc (retire_pc),
        .wb_en     (wb_en),
        .wb_id     (wb_id),
        .wb_data   (wb_data),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: program words in imem, stores shadow them in dmem until reset.
    logic [31:0]  imem [0:127];
    logic [31:0]  dmem [0:127];
    logic [127:0] dvalid;
    logic [7:0]   wcnt;
    logic         slow;
    logic [6:0]   midx;

    assign midx      = mem_addr[8:2];
    assign mem_ready = (wcnt >= (slow ? 8'd3 : 8'd0));
    assign mem_rdata = dvalid[midx] ? dmem[midx] : imem[midx];

    always @(posedge clk) begin
        if (rst) begin
            dvalid <= '0;
            wcnt   <= 8'd0;
        end else begin
            if (mem_req && mem_ready) wcnt <= 8'd0;
            else if (mem_req)         wcnt <= wcnt + 8'd1;
            else                      wcnt <= 8'd0;
            if (mem_req && mem_ready && mem_we) begin
                dmem[midx]   <= mem_wdata;
                dvalid[midx] <= 1'b1;
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  id;
        logic [31:0] data;
        int          cpi;
        logic [31:0] npc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];

    task automatic push(input logic [31:0] pc, input logic wen,
                        input logic [4:0] id, input logic [31:0] data,
                        input int cpi, input logic [31:0] npc);
        exp_t e;
        e.pc   = pc;
        e.wen  = wen;
        e.id   = id;
        e.data = data;
        e.cpi  = cpi;
        e.npc  = npc;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    // Monitor: scoreboard pops on retire, store queue pops on write.
    int          last_cyc = 0;
    logic        chk_next = 1'b0;
    logic [31:0] next_pc;
    logic        pw = 1'b0;
    logic [1:0]  p_ctl;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    always @(negedge clk) begin
        if (rst) begin
            last_cyc = cyc;
            chk_next = 1'b0;
            pw       = 1'b0;
        end else begin
            if (chk_next) begin
                check("next_fetch_req", mem_req, 1'b1);
                check("next_fetch_addr", mem_addr, next_pc);
                chk_next = 1'b0;
            end
            if (pw) begin
                check("wait_ctl_stable", {mem_req, mem_we}, p_ctl);
                check("wait_addr_stable", mem_addr, p_addr);
                check("wait_wdata_stable", mem_wdata, p_wdata);
            end
            if (mem_req && mem_ready && mem_we) begin
                check("store_expected", wq_addr.size() != 0, 1'b1);
                if (wq_addr.size() != 0) begin
                    check("store_addr", mem_addr, wq_addr.pop_front());
                    check("store_data", mem_wdata, wq_data.pop_front());
                end
            end
            if (retire) begin
                check("retire_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("retire_pc", retire_pc, e.pc);
                    check("wb_en", wb_en, e.wen);
                    if (e.wen) begin
                        check("wb_id", wb_id, e.id);
                        check("wb_data", wb_data, e.data);
                    end
                    check("cycles", cyc - last_cyc, e.cpi);
                    chk_next = 1'b1;
                    next_pc  = e.npc;
                end
                last_cyc = cyc;
            end
            pw      = mem_req && !mem_ready;
            p_ctl   = {mem_req, mem_we};
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
        end
    end

    task automatic wait_retire(input logic [31:0] pc, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(retire && retire_pc === pc) && n < max);
        check("reach_retire", retire_pc, pc);
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        slow = 1'b0;
        for (int k = 0; k < 128; k++) imem[k] = 32'd0;
        imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        imem[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2a);
        imem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        imem[5]  = enc_i(6'h08, 5'd0, 5'd6, 16'd99);
        imem[6]  = enc_i(6'h08, 5'd0, 5'd6, 16'd99);
        imem[7]  = {6'h02, 26'h40};
        imem[64] = enc_i(6'h2b, 5'd0, 5'd3, 16'd8);
        imem[65] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        imem[66] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        imem[67] = enc_r(5'd0, 5'd5, 5'd7, 6'h20);
        imem[68] = enc_r(5'd5, 5'd1, 5'd8, 6'h22);
        imem[69] = enc_r(5'd1, 5'd3, 5'd9, 6'h25);
        imem[70] = enc_r(5'd1, 5'd4, 5'd10, 6'h24);
        imem[71] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
        imem[72] = 32'hFC00_0000;
        imem[74] = enc_i(6'h08, 5'd0, 5'd11, 16'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_retire", retire, 1'b0);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_halted", halted, 1'b0);

        push(32'h00, 1'b1, 5'd1, 32'd5, 4, 32'h04);
        push(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFD, 4, 32'h08);
        push(32'h08, 1'b1, 5'd3, 32'd2, 4, 32'h0C);
        push(32'h0C, 1'b1, 5'd4, 32'd1, 4, 32'h10);
        push(32'h10, 1'b0, 5'd0, 32'd0, 3, 32'h1C);
        push(32'h1C, 1'b0, 5'd0, 32'd0, 3, 32'h100);
        push(32'h100, 1'b0, 5'd0, 32'd0, 10, 32'h104);
        push(32'h104, 1'b1, 5'd5, 32'd2, 11, 32'h108);
        push(32'h108, 1'b0, 5'd0, 32'd0, 4, 32'h10C);
        push(32'h10C, 1'b1, 5'd7, 32'd2, 4, 32'h110);
        push(32'h110, 1'b1, 5'd8, 32'hFFFF_FFFD, 4, 32'h114);
        push(32'h114, 1'b1, 5'd9, 32'd7, 4, 32'h118);
        push(32'h118, 1'b1, 5'd10, 32'd1, 4, 32'h11C);
        push(32'h11C, 1'b0, 5'd0, 32'd0, 3, 32'h120);
        wq_addr.push_back(32'h8);
        wq_data.push_back(32'd2);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 32'h0);
        check("first_we", mem_we, 1'b0);

        wait_retire(32'h1C, 200);
        slow = 1'b1;
        wait_retire(32'h104, 200);
        slow = 1'b0;
        wait_drain(300);

        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("halt_state", {halted, mem_req, retire}, 3'b100);
            @(negedge clk);
        end
        check("store_queue_empty_a", wq_addr.size(), 0);

        @(posedge clk);
        #1 rst = 1'b1;
        imem[0] = enc_r(5'd5, 5'd7, 5'd6, 6'h20);
        imem[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[3] = enc_i(6'h08, 5'd0, 5'd3, 16'd9);
        imem[4] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
        imem[5] = enc_i(6'h2b, 5'd0, 5'd3, 16'd12);
        push(32'h00, 1'b1, 5'd6, 32'd0, 4, 32'h04);
        push(32'h04, 1'b1, 5'd1, 32'd5, 4, 32'h08);
        push(32'h08, 1'b1, 5'd2, 32'hFFFF_FFFD, 4, 32'h0C);
        push(32'h0C, 1'b1, 5'd3, 32'd9, 4, 32'h10);
        push(32'h10, 1'b0, 5'd0, 32'd0, 3, 32'h14);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        wait_retire(32'h10, 200);
        slow = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!(mem_req && mem_we) && n < 40);
        check("sw_mem_seen", {mem_req, mem_we}, 2'b11);
        check("sw_mem_addr", mem_addr, 32'hC);
        check("sw_mem_wdata", mem_wdata, 32'd9);
        check("sw_waiting", mem_ready, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", mem_req, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_req_next", {mem_req, mem_we}, 2'b00);
        check("midrst_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1 slow = 1'b0;
        push(32'h00, 1'b1, 5'd6, 32'd0, 4, 32'h04);
        rst = 1'b0;
        @(negedge clk);
        check("refetch_req", mem_req, 1'b1);
        check("refetch_addr", mem_addr, 32'h0);
        wait_drain(100);
        repeat (2) @(negedge clk);
        check("no_store_after_rst", dvalid[3], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
